// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction size, default reset
// PC and the branch opcode constants also used by the branch-condition evaluator.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // RV32 control-transfer opcodes and branch funct3 codes
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Combinational next-PC select: reset > redirect > sequential > hold, with
// target word-alignment masking and misalignment detection.
module pc_next_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned       bits     = 32,
  parameter logic [bits-1:0]   RESET_PC = bits'(DEFAULT_RESET_PC)
) (
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic            advance_i,
  input  logic [bits-1:0] pc_i,
  input  logic [bits-1:0] target_i,
  output logic [bits-1:0] pc_o,
  output logic            misalign_o
);

  always_comb begin
    pc_o       = pc_i;
    misalign_o = 1'b0;
    if (rst_i) begin
      pc_o = RESET_PC;
    end else if (redirect_i) begin
      // low bits are dropped; the target is still taken when misaligned
      pc_o       = {target_i[bits-1:2], 2'b00};
      misalign_o = |target_i[1:0];
    end else if (advance_i) begin
      pc_o = pc_i + bits'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues fetches, holds under stall and
// redirects/flushes on taken branches and jumps.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned     bits     = 32,
  parameter logic [bits-1:0] RESET_PC = bits'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_en,
  input  logic            branch_cond,
  input  logic            jump_en,
  input  logic [bits-1:0] target_addr,
  input  logic            stall,
  output logic [bits-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [bits-1:0] instr_pc,
  output logic            instr_valid,
  output logic            flush,
  output logic            misalign_err
);

  fetch_state_e    state_q;
  logic [bits-1:0] pc_q, pc_d;
  logic [31:0]     instr_q;
  logic [bits-1:0] instr_pc_q;
  logic            valid_q, flush_q, misalign_q;
  logic            taken, redirect, advance, misalign;

  assign taken    = (branch_en & branch_cond) | jump_en;
  assign redirect = taken && (state_q != ST_START);
  assign advance  = (state_q == ST_FETCH) && imem_ready;

  pc_next_sel #(.bits(bits), .RESET_PC(RESET_PC)) u_pc_next_sel (
    .rst_i      (rst),
    .redirect_i (redirect),
    .advance_i  (advance),
    .pc_i       (pc_q),
    .target_i   (target_addr),
    .pc_o       (pc_d),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (rst) begin
      state_q    <= ST_START;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (state_q == ST_START) begin
        state_q <= ST_FETCH;
      end else if (redirect) begin
        // any same-cycle response belongs to the wrong path and is dropped
        valid_q    <= 1'b0;
        flush_q    <= 1'b1;
        misalign_q <= misalign;
        state_q    <= ST_FETCH;
      end else begin
        case (state_q)
          ST_FETCH: begin
            if (imem_ready) begin
              instr_q    <= imem_rdata;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              state_q    <= stall ? ST_HOLD : ST_FETCH;
            end else if (!stall) begin
              valid_q <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall) state_q <= ST_FETCH;
          end
          default: state_q <= ST_START;
        endcase
      end
    end
  end

  assign imem_addr    = pc_q;
  assign imem_req     = (state_q == ST_FETCH);
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit; a second instance starts near the
// top of the address space to exercise PC wrap.
module tb_fetch_pc_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst, branch_en, branch_cond, jump_en, stall, imem_ready;
  logic [31:0] target_addr;

  logic [31:0] m_addr, m_rdata, m_instr, m_ipc;
  logic        m_req, m_valid, m_flush, m_mis;
  logic [31:0] w_addr, w_rdata, w_instr, w_ipc;
  logic        w_req, w_valid, w_flush, w_mis;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // instruction memory model: word derived from its address
  assign m_rdata = m_addr ^ KEY;
  assign w_rdata = w_addr ^ KEY;

  fetch_pc_unit #(.bits(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .branch_en(branch_en), .branch_cond(branch_cond),
    .jump_en(jump_en), .target_addr(target_addr), .stall(stall),
    .imem_addr(m_addr), .imem_req(m_req), .imem_ready(imem_ready),
    .imem_rdata(m_rdata), .instr(m_instr), .instr_pc(m_ipc),
    .instr_valid(m_valid), .flush(m_flush), .misalign_err(m_mis)
  );

  fetch_pc_unit #(.bits(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .branch_en(branch_en), .branch_cond(branch_cond),
    .jump_en(jump_en), .target_addr(target_addr), .stall(stall),
    .imem_addr(w_addr), .imem_req(w_req), .imem_ready(imem_ready),
    .imem_rdata(w_rdata), .instr(w_instr), .instr_pc(w_ipc),
    .instr_valid(w_valid), .flush(w_flush), .misalign_err(w_mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; branch_en = 1'b0; branch_cond = 1'b0; jump_en = 1'b0;
    stall = 1'b0; imem_ready = 1'b1; target_addr = 32'h0;
    tick(); tick();
    chk("rst_req",   32'(m_req),   32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_flush", 32'(m_flush), 32'h0);
    chk("rst_mis",   32'(m_mis),   32'h0);
    chk("rst_ipc",   m_ipc,        32'h0);
    chk("rst_instr", m_instr,      32'h0);
    chk("rst_addr",  m_addr,       32'h0);
    chk("w_rst_addr", w_addr,      32'hFFFF_FFF8);

    // START cycle: no request
    rst = 1'b0;
    #1 chk("start_req", 32'(m_req), 32'h0);
    tick();
    chk("f0_req",   32'(m_req),   32'h1);
    chk("f0_addr",  m_addr,       32'h0);
    chk("f0_valid", 32'(m_valid), 32'h0);
    chk("w_f0_addr", w_addr,      32'hFFFF_FFF8);
    tick();
    chk("f1_addr",  m_addr,       32'h4);
    chk("f1_ipc",   m_ipc,        32'h0);
    chk("f1_valid", 32'(m_valid), 32'h1);
    chk("f1_instr", m_instr,      32'h0 ^ KEY);
    chk("w_f1_addr", w_addr,      32'hFFFF_FFFC);
    chk("w_f1_ipc",  w_ipc,       32'hFFFF_FFF8);
    tick();
    chk("f2_addr",  m_addr,       32'h8);
    chk("f2_ipc",   m_ipc,        32'h4);
    chk("w_wrap_addr", w_addr,    32'h0);
    chk("w_wrap_ipc",  w_ipc,     32'hFFFF_FFFC);

    // stall for 3 cycles starting with the fetch of 0x8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req",   32'(m_req),   32'h0);
      chk("stall_ipc",   m_ipc,        32'h8);
      chk("stall_valid", 32'(m_valid), 32'h1);
      chk("stall_addr",  m_addr,       32'hC);
    end
    stall = 1'b0;
    tick();
    chk("rel_req",  32'(m_req), 32'h1);
    chk("rel_addr", m_addr,     32'hC);
    chk("rel_ipc",  m_ipc,      32'h8);
    tick();
    chk("rel_ipc2",   m_ipc,   32'hC);
    chk("rel_instr2", m_instr, 32'hC ^ KEY);
    chk("rel_addr2",  m_addr,  32'h10);

    // taken branch collides with a response at 0x10
    branch_en = 1'b1; branch_cond = 1'b1; target_addr = 32'h40;
    tick();
    chk("br_flush", 32'(m_flush), 32'h1);
    chk("br_valid", 32'(m_valid), 32'h0);
    chk("br_addr",  m_addr,       32'h40);
    chk("br_mis",   32'(m_mis),   32'h0);
    branch_en = 1'b0; branch_cond = 1'b0;
    tick();
    chk("br_flush_end", 32'(m_flush), 32'h0);
    chk("br_tgt_ipc",   m_ipc,        32'h40);
    chk("br_tgt_valid", 32'(m_valid), 32'h1);
    chk("br_tgt_addr",  m_addr,       32'h44);

    // branch not taken
    branch_en = 1'b1; branch_cond = 1'b0; target_addr = 32'h80;
    tick();
    chk("nt_flush", 32'(m_flush), 32'h0);
    chk("nt_ipc",   m_ipc,        32'h44);
    chk("nt_addr",  m_addr,       32'h48);
    branch_en = 1'b0;

    // misaligned jump
    jump_en = 1'b1; target_addr = 32'h102;
    tick();
    chk("jmp_flush", 32'(m_flush), 32'h1);
    chk("jmp_mis",   32'(m_mis),   32'h1);
    chk("jmp_addr",  m_addr,       32'h100);
    chk("jmp_valid", 32'(m_valid), 32'h0);
    jump_en = 1'b0;
    tick();
    chk("jmp_mis_end", 32'(m_mis),   32'h0);
    chk("jmp_ipc",     m_ipc,        32'h100);
    chk("jmp_addr2",   m_addr,       32'h104);

    // back-to-back redirects: latest wins
    jump_en = 1'b1; target_addr = 32'h200;
    tick();
    chk("b2b_flush0", 32'(m_flush), 32'h1);
    chk("b2b_addr0",  m_addr,       32'h200);
    target_addr = 32'h300;
    tick();
    chk("b2b_flush1", 32'(m_flush), 32'h1);
    chk("b2b_addr1",  m_addr,       32'h300);
    chk("b2b_valid",  32'(m_valid), 32'h0);
    jump_en = 1'b0;
    tick();
    chk("b2b_flush2", 32'(m_flush), 32'h0);
    chk("b2b_ipc",    m_ipc,        32'h300);

    // memory not ready while decode consumes
    imem_ready = 1'b0;
    tick();
    chk("nr_valid", 32'(m_valid), 32'h0);
    chk("nr_addr",  m_addr,       32'h304);
    chk("nr_req",   32'(m_req),   32'h1);
    imem_ready = 1'b1;

    // enter HOLD, then reset with a redirect pending
    stall = 1'b1;
    tick();
    chk("hold_valid", 32'(m_valid), 32'h1);
    chk("hold_ipc",   m_ipc,        32'h304);
    rst = 1'b1; jump_en = 1'b1; target_addr = 32'h500;
    tick();
    chk("hrst_valid", 32'(m_valid), 32'h0);
    chk("hrst_addr",  m_addr,       32'h0);
    chk("hrst_flush", 32'(m_flush), 32'h0);
    chk("hrst_req",   32'(m_req),   32'h0);
    chk("w_hrst_addr", w_addr,      32'hFFFF_FFF8);

    // redirect during START is ignored
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("st_flush", 32'(m_flush), 32'h0);
    chk("st_addr",  m_addr,       32'h0);
    chk("st_req",   32'(m_req),   32'h1);
    jump_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
